multicycle_ctrl: RTL and testbench

Main control FSM for the 32-bit multicycle CPU. It sequences the shared datapath (PC, IR, MDR, A/B operand registers, ALUOut, single memory port) through fetch, decode, execute, memory and writeback steps, one state per clock. Memory accesses wait on a ready handshake. The FSM drives every datapath enable and mux select, plus the ALU operation class.

---
 rtl/multicycle_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the 32-bit multicycle CPU: sequences the shared datapath
// one state per clock and aborts memory accesses that exceed WAIT_MAX wait cycles.
module multicycle_ctrl #(
  parameter int OPW      = 6,
  parameter int WAIT_MAX = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic           i_or_d,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ir_write,
  output logic           mem_to_reg,
  output logic           reg_dst,
  output logic           reg_write,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_source,
  output logic           illegal_op,
  output logic           bus_err,
  output logic [3:0]     state_o
);

  localparam logic [3:0] S_RESET  = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_ADDIEX = 4'd11;
  localparam logic [3:0] S_ADDIWB = 4'd12;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);

  localparam logic [3:0] WMAX = 4'(WAIT_MAX);

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [3:0] wcnt;
  logic       waiting;
  logic       timeout;
  logic       illegal_dec;

  assign waiting = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  // mem_ready arriving on the final count still completes the access
  assign timeout = waiting && !mem_ready && (wcnt == WMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RESET;
      wcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      // leaving a wait state (success or abort) always clears, so entry sees zero
      wcnt  <= (waiting && !mem_ready && !timeout) ? wcnt + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    state_nxt   = S_RESET;
    illegal_dec = 1'b0;
    case (state)
      S_RESET:  state_nxt = S_FETCH;
      S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          OP_ADDI:      state_nxt = S_ADDIEX;
          default: begin
            state_nxt   = S_FETCH;
            illegal_dec = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_nxt = S_FETCH;
      S_MEMWR:  state_nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_nxt = S_ALUWB;
      S_ALUWB:  state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      S_JUMP:   state_nxt = S_FETCH;
      S_ADDIEX: state_nxt = S_ADDIWB;
      S_ADDIWB: state_nxt = S_FETCH;
      default:  state_nxt = S_RESET;
    endcase
    if (timeout) state_nxt = S_FETCH;
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_ADDIWB: reg_write = 1'b1;
      default: ;
    endcase
    // a reset arriving mid-access must not let a write land on its final edge
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
    end
  end

  assign illegal_op = illegal_dec && !rst;
  assign bus_err    = timeout && !rst;
  assign state_o    = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected state paths
// and per-state control words, driven with randomized opcodes and wait patterns.
module tb_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       illegal_op, bus_err;
  logic [3:0] state_o;

  multicycle_ctrl #(.OPW(6), .WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .bus_err(bus_err),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] RTYPE = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;

  typedef struct {
    logic [3:0] st;
    logic       mr;
    logic       ill;
    logic       be;
    logic [5:0] op;
  } step_t;

  step_t plan[$];
  int checks = 0;
  int errors = 0;

  logic [15:0] ctl;
  assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  // Control word the specification lists for each state, same bit order as ctl.
  function automatic logic [15:0] exp_ctl(input logic [3:0] st, input logic mr);
    logic [15:0] v;
    case (st)
      4'd1: begin v = 16'h1010; v[15] = mr; v[10] = mr; end
      4'd2:  v = 16'h0030;
      4'd3:  v = 16'h0060;
      4'd4:  v = 16'h3000;
      4'd5:  v = 16'h0280;
      4'd6:  v = 16'h2800;
      4'd7:  v = 16'h0048;
      4'd8:  v = 16'h0180;
      4'd9:  v = 16'h4045;
      4'd10: v = 16'h8002;
      4'd11: v = 16'h0060;
      4'd12: v = 16'h0080;
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return (op == RTYPE) || (op == LW) || (op == SW) || (op == BEQ) || (op == J) || (op == ADDI);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s state_o=%0d observed=%h expected=%h", tag, state_o, obs, exp);
    end
  endtask

  task automatic add(input logic [3:0] st, input logic mr, input logic ill,
                     input logic be, input logic [5:0] op);
    step_t s;
    s.st = st; s.mr = mr; s.ill = ill; s.be = be; s.op = op;
    plan.push_back(s);
  endtask

  task automatic add_wait(input logic [3:0] st, input int n, input logic [5:0] op);
    for (int i = 0; i < n; i++) add(st, 1'b0, 1'b0, 1'b0, op);
  endtask

  task automatic add_fetch_timeout(input logic [5:0] op);
    add_wait(4'd1, 15, op);
    add(4'd1, 1'b0, 1'b0, 1'b1, op);
  endtask

  // One instruction: fetch with fw wait cycles, then its path; mto aborts the memory step.
  task automatic add_instr(input logic [5:0] op, input int fw, input int mw, input logic mto);
    add_wait(4'd1, fw, op);
    add(4'd1, 1'b1, 1'b0, 1'b0, op);
    add(4'd2, 1'($urandom), !is_legal(op), 1'b0, op);
    case (op)
      LW, SW: begin
        add(4'd3, 1'($urandom), 1'b0, 1'b0, op);
        if (mto) begin
          add_wait((op == LW) ? 4'd4 : 4'd6, 15, op);
          add((op == LW) ? 4'd4 : 4'd6, 1'b0, 1'b0, 1'b1, op);
        end else begin
          add_wait((op == LW) ? 4'd4 : 4'd6, mw, op);
          add((op == LW) ? 4'd4 : 4'd6, 1'b1, 1'b0, 1'b0, op);
          if (op == LW) add(4'd5, 1'($urandom), 1'b0, 1'b0, op);
        end
      end
      RTYPE: begin
        add(4'd7, 1'($urandom), 1'b0, 1'b0, op);
        add(4'd8, 1'($urandom), 1'b0, 1'b0, op);
      end
      BEQ:  add(4'd9, 1'($urandom), 1'b0, 1'b0, op);
      J:    add(4'd10, 1'($urandom), 1'b0, 1'b0, op);
      ADDI: begin
        add(4'd11, 1'($urandom), 1'b0, 1'b0, op);
        add(4'd12, 1'($urandom), 1'b0, 1'b0, op);
      end
      default: ;
    endcase
  endtask

  // Each step is exactly one clock; called at posedge+1 and returns at posedge+1.
  task automatic run_plan();
    step_t s;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      opcode    = s.op;
      mem_ready = s.mr;
      zero      = 1'($urandom);
      #1;
      chk("state", 16'(state_o), 16'(s.st));
      chk("ctl", ctl, exp_ctl(s.st, s.mr));
      chk("illegal_op", 16'(illegal_op), 16'(s.ill));
      chk("bus_err", 16'(bus_err), 16'(s.be));
      @(posedge clk); #1;
    end
  endtask

  task automatic release_and_check();
    rst = 1'b0;
    #1;
    chk("rst_state", 16'(state_o), 16'd0);
    chk("rst_ctl", ctl, 16'h0000);
    chk("rst_flags", {14'd0, illegal_op, bus_err}, 16'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] ops [6];
    ops[0] = RTYPE; ops[1] = LW; ops[2] = SW; ops[3] = BEQ; ops[4] = J; ops[5] = ADDI;
    rst = 1'b1; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    release_and_check();

    // LW, then stall mid-MEMRD and reset for 3 cycles
    add_instr(LW, 0, 0, 1'b0);
    add_instr(LW, 0, 0, 1'b0);
    void'(plan.pop_back()); void'(plan.pop_back());
    add_wait(4'd4, 2, LW);
    run_plan();
    rst = 1'b1; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    release_and_check();

    add_instr(SW, 0, 3, 1'b0);
    add_instr(BEQ, 0, 0, 1'b0);
    add_instr(6'b111111, 0, 0, 1'b0);
    add_fetch_timeout(J);
    add_instr(J, 0, 0, 1'b0);
    add_wait(4'd1, 15, ADDI);              // ready on the final count is a success
    add_instr(ADDI, 0, 0, 1'b0);
    add_instr(LW, 1, 0, 1'b1);
    add_instr(SW, 2, 0, 1'b1);
    add_instr(RTYPE, 0, 0, 1'b0);
    run_plan();

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 6) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      if ($urandom_range(0, 9) == 0) add_fetch_timeout(op);
      add_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 11) == 0));
      run_plan();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
